// File: rtl/data_mem_ctl.sv
// data_mem_ctl -- single-port data memory with masked writes, a registered
// read port and a hardware clear sweep.
//
// The memory array is never reset directly. Instead, a two-state FSM
// (IDLE/SWEEP) walks a pointer across every word and writes CLEAR_VAL to each
// one. Requests are ignored while the sweep runs. Reset restarts the sweep, so
// after reset the memory holds a known value once Busy falls.
//
// Parameters
//   DATA_W     data word width in bits (>= 1)
//   ADDR_W     address width; depth is 2**ADDR_W words
//   CLEAR_VAL  word written to every location by a clear sweep
//
// Ports
//   Clk          sole clock, rising edge
//   Reset        asynchronous, active-high; forces SWEEP from address 0
//   Clear        single-cycle request to start a clear sweep (IDLE only)
//   MEM_READ     read request (IDLE only)
//   MEM_WRITE    write request (IDLE only)
//   DataAddress  word address for read and write
//   WriteData    write data
//   WriteMask    per-bit write enable, 1 = bit is updated
//   ReadData     registered read data; holds between reads
//   ReadValid    one-cycle pulse marking a new ReadData value
//   Busy         high while a clear sweep is in progress
module data_mem_ctl #(
  parameter int unsigned           DATA_W    = 8,
  parameter int unsigned           ADDR_W    = 8,
  parameter logic [DATA_W-1:0]     CLEAR_VAL = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Clear,
  input  logic              MEM_READ,
  input  logic              MEM_WRITE,
  input  logic [ADDR_W-1:0] DataAddress,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [DATA_W-1:0] WriteMask,
  output logic [DATA_W-1:0] ReadData,
  output logic              ReadValid,
  output logic              Busy
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_next;

  logic [DATA_W-1:0] core [DEPTH];

  logic rd_accept;
  logic wr_accept;
  logic sweep_we;

  // Requests only take effect in IDLE; during a sweep they are dropped.
  assign rd_accept = (state == IDLE) && MEM_READ;
  assign wr_accept = (state == IDLE) && MEM_WRITE;
  assign sweep_we  = (state == SWEEP);
  assign Busy      = (state == SWEEP);

  // ---------------------------------------------------------------------------
  // FSM state and clear pointer
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= SWEEP;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // NOTE: defaults are assigned first so every path drives every output and
  // no latch is inferred.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    unique case (state)
      IDLE: begin
        if (Clear) begin
          state_next = SWEEP;
          ptr_next   = '0;
        end
      end
      SWEEP: begin
        // The pointer wraps to 0 on the same edge that clears the last word.
        ptr_next = ptr + PTR_ONE;
        if (ptr == PTR_LAST) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = SWEEP;
        ptr_next   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory array
  // ---------------------------------------------------------------------------
  // NOTE: the array has no reset; its contents are defined only by the sweep,
  // which keeps it mappable onto block RAM.
  always_ff @(posedge Clk) begin
    if (sweep_we) begin
      core[ptr] <= CLEAR_VAL;
    end else if (wr_accept) begin
      core[DataAddress] <= (core[DataAddress] & ~WriteMask) |
                           (WriteData & WriteMask);
    end
  end

  // ---------------------------------------------------------------------------
  // Registered read port
  // ---------------------------------------------------------------------------
  // The read samples core[] before the same-edge write lands, which gives
  // read-before-write on a simultaneous read and write of one address.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      ReadData  <= '0;
      ReadValid <= 1'b0;
    end else begin
      ReadValid <= rd_accept;
      if (rd_accept) begin
        ReadData <= core[DataAddress];
      end
    end
  end

endmodule

// File: tb/tb_data_mem_ctl.sv
// tb_data_mem_ctl -- directed, table-driven bench for data_mem_ctl.
// Instance dut uses default parameters; dut2 uses DATA_W=16, ADDR_W=4,
// CLEAR_VAL=16'hBEEF. Both share clock and reset.
module tb_data_mem_ctl;

  logic       clk;
  logic       rst;

  logic       clr, rd, wr;
  logic [7:0] addr, wdata, mask;
  logic [7:0] rdata;
  logic       rvalid, busy;

  logic        clr2, rd2, wr2;
  logic [3:0]  addr2;
  logic [15:0] wdata2, mask2;
  logic [15:0] rdata2;
  logic        rvalid2, busy2;

  int n_cmp  = 0;
  int n_fail = 0;

  data_mem_ctl dut (
    .Clk         (clk),
    .Reset       (rst),
    .Clear       (clr),
    .MEM_READ    (rd),
    .MEM_WRITE   (wr),
    .DataAddress (addr),
    .WriteData   (wdata),
    .WriteMask   (mask),
    .ReadData    (rdata),
    .ReadValid   (rvalid),
    .Busy        (busy)
  );

  data_mem_ctl #(
    .DATA_W    (16),
    .ADDR_W    (4),
    .CLEAR_VAL (16'hBEEF)
  ) dut2 (
    .Clk         (clk),
    .Reset       (rst),
    .Clear       (clr2),
    .MEM_READ    (rd2),
    .MEM_WRITE   (wr2),
    .DataAddress (addr2),
    .WriteData   (wdata2),
    .WriteMask   (mask2),
    .ReadData    (rdata2),
    .ReadValid   (rvalid2),
    .Busy        (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clr = 0; rd = 0; wr = 0; addr = '0; wdata = '0; mask = '0;
    clr2 = 0; rd2 = 0; wr2 = 0; addr2 = '0; wdata2 = '0; mask2 = '0;
  endtask

  // Counts edges until dut Busy falls, starting from an initial count.
  task automatic wait_busy(input int start, input int exp, input string name);
    int n;
    n = start;
    while (busy && n < exp + 50) begin
      tick();
      n++;
    end
    check(name, n, exp);
  endtask

  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] mask;
    logic       exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[17];

  initial begin
    int n, n2;

    //            rd wr addr   wdata  mask   vld data
    vecs[0]  = '{1, 0, 8'h00, 8'h00, 8'h00, 1, 8'h00};
    vecs[1]  = '{1, 0, 8'h80, 8'h00, 8'h00, 1, 8'h00};
    vecs[2]  = '{1, 0, 8'hFF, 8'h00, 8'h00, 1, 8'h00};
    vecs[3]  = '{0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h00};
    vecs[4]  = '{0, 1, 8'h10, 8'hA5, 8'hFF, 0, 8'h00};
    vecs[5]  = '{0, 1, 8'h10, 8'h0F, 8'h0F, 0, 8'h00};
    vecs[6]  = '{1, 0, 8'h10, 8'h00, 8'h00, 1, 8'hAF};
    vecs[7]  = '{0, 1, 8'h05, 8'h11, 8'hFF, 0, 8'hAF};
    vecs[8]  = '{1, 1, 8'h05, 8'h3C, 8'hFF, 1, 8'h11};
    vecs[9]  = '{1, 0, 8'h05, 8'h00, 8'h00, 1, 8'h3C};
    vecs[10] = '{0, 0, 8'h00, 8'h00, 8'h00, 0, 8'h3C};
    vecs[11] = '{0, 1, 8'h20, 8'hF0, 8'h3C, 0, 8'h3C};
    vecs[12] = '{1, 0, 8'h20, 8'h00, 8'h00, 1, 8'h30};
    vecs[13] = '{1, 0, 8'h10, 8'h00, 8'h00, 1, 8'hAF};
    vecs[14] = '{1, 0, 8'hFF, 8'h00, 8'h00, 1, 8'h00};
    vecs[15] = '{0, 1, 8'hFF, 8'h81, 8'hFF, 0, 8'h00};
    vecs[16] = '{1, 0, 8'hFF, 8'h00, 8'h00, 1, 8'h81};

    idle_inputs();
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("reset busy", busy, 1);
    check("reset rvalid", rvalid, 0);
    check("reset rdata", rdata, 0);
    check("reset busy2", busy2, 1);

    // Hold reset over a few edges; Busy stays high throughout.
    tick();
    tick();
    check("busy during reset", busy, 1);
    rst = 1'b0;

    // Sweep lengths after release: 256 for dut, 16 for dut2.
    n  = 0;
    n2 = -1;
    while ((busy || busy2) && n < 400) begin
      tick();
      n++;
      if (!busy2 && n2 < 0) n2 = n;
    end
    check("sweep length dut", n, 256);
    check("sweep length dut2", n2, 16);

    // Wide instance: cleared contents and masked write.
    rd2 = 1; addr2 = 4'd15;
    tick();
    check("dut2 rd15 valid", rvalid2, 1);
    check("dut2 rd15 data", rdata2, 16'hBEEF);
    rd2 = 0; wr2 = 1; addr2 = 4'd2; wdata2 = 16'h1234; mask2 = 16'hFF00;
    tick();
    wr2 = 0; rd2 = 1;
    tick();
    check("dut2 masked write", rdata2, 16'h12EF);
    idle_inputs();

    // Table-driven single-cycle vectors on the default instance.
    for (int i = 0; i < 17; i++) begin
      rd = vecs[i].rd; wr = vecs[i].wr; addr = vecs[i].addr;
      wdata = vecs[i].wdata; mask = vecs[i].mask;
      tick();
      check($sformatf("vec%0d valid", i), rvalid, vecs[i].exp_valid);
      check($sformatf("vec%0d data", i), rdata, vecs[i].exp_data);
    end
    idle_inputs();

    // Reset immediately after a read completes: outputs clear without a clock.
    rd = 1; addr = 8'h10;
    tick();
    check("pre-reset valid", rvalid, 1);
    check("pre-reset data", rdata, 8'hAF);
    rd = 0;
    rst = 1'b1;
    #1;
    check("mid-read reset valid", rvalid, 0);
    check("mid-read reset data", rdata, 0);
    check("mid-read reset busy", busy, 1);
    tick();
    rst = 1'b0;
    wait_busy(0, 256, "sweep after mid-read reset");

    // Clear with a simultaneous read; then requests ignored during the sweep.
    wr = 1; addr = 8'h07; wdata = 8'h42; mask = 8'hFF;
    tick();
    wr = 0; clr = 1; rd = 1;
    tick();
    check("clear edge busy", busy, 1);
    check("clear edge read valid", rvalid, 1);
    check("clear edge read data", rdata, 8'h42);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      clr = 1; rd = 1; wr = 1; addr = 8'h07; wdata = 8'hFF; mask = 8'hFF;
      tick();
      n++;
      check($sformatf("sweep ignore valid %0d", i), rvalid, 0);
    end
    check("sweep ignore data hold", rdata, 8'h42);
    idle_inputs();
    wait_busy(n, 256, "clear sweep length");
    rd = 1; addr = 8'h07;
    tick();
    check("addr7 after clear valid", rvalid, 1);
    check("addr7 after clear data", rdata, 8'h00);
    addr = 8'h10;
    tick();
    check("addr10 after clear data", rdata, 8'h00);
    idle_inputs();

    // Reset in cycle 40 of a sweep.
    wr = 1; addr = 8'h03; wdata = 8'h5A; mask = 8'hFF;
    tick();
    wr = 0; rd = 1;
    tick();
    check("pre-sweep read data", rdata, 8'h5A);
    rd = 0; clr = 1;
    tick();
    clr = 0;
    repeat (39) tick();
    check("busy at sweep cycle 40", busy, 1);
    rst = 1'b1;
    #1;
    check("mid-sweep reset data", rdata, 0);
    check("mid-sweep reset valid", rvalid, 0);
    tick();
    tick();
    rst = 1'b0;
    wait_busy(0, 256, "sweep after mid-sweep reset");
    check("data after mid-sweep reset", rdata, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_ctl.md
DATA_MEM_CTL -- requirements
Module: data_mem_ctl

Interface
REQ-001 The block SHALL take parameter DATA_W, default 8, meaning data word width in bits (any value >= 1).
REQ-002 The block SHALL take parameter ADDR_W, default 8, meaning address width; depth = 2**ADDR_W words.
REQ-003 The block SHALL take parameter CLEAR_VAL, default 0, meaning the DATA_W-bit word written to every location by a clear sweep.
REQ-004 Port: Clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 Port: Reset  input  1  asynchronous, active-high reset.
REQ-006 Port: Clear  input  1  single-cycle request to start a clear sweep.
REQ-007 Port: MEM_READ  input  1  read request.
REQ-008 Port: MEM_WRITE  input  1  write request.
REQ-009 Port: DataAddress  input  ADDR_W  word address for read and write.
REQ-010 Port: WriteData  input  DATA_W  write data.
REQ-011 Port: WriteMask  input  DATA_W  per-bit write enable; 1 = bit is updated.
REQ-012 Port: ReadData  output  DATA_W  registered read data.
REQ-013 Port: ReadValid  output  1  one-cycle pulse marking a new ReadData value.
REQ-014 Port: Busy  output  1  high while a clear sweep is in progress; requests are ignored.

Function
REQ-015 The FSM SHALL have exactly two states, IDLE and SWEEP, and a clear pointer of width ADDR_W.
REQ-016 In SWEEP, each cycle SHALL write CLEAR_VAL to Core[ptr], then increment ptr.
REQ-017 SWEEP SHALL exit to IDLE on the edge that writes address 2**ADDR_W-1, taking 2**ADDR_W cycles in total; the pointer wraps to 0.
REQ-018 Busy SHALL equal (state == SWEEP), combinationally from the state register.
REQ-019 In IDLE, Clear=1 SHALL move the FSM to SWEEP with ptr=0 on the next edge; MEM_READ and MEM_WRITE in that same cycle still execute.
REQ-020 In SWEEP, Clear, MEM_READ and MEM_WRITE SHALL be ignored: no memory update, no ReadValid, and the sweep does not restart.
REQ-021 In IDLE with MEM_WRITE=1, the edge SHALL set Core[DataAddress] to (old & ~WriteMask) | (WriteData & WriteMask).
REQ-022 In IDLE with MEM_READ=1, the edge SHALL load ReadData with Core[DataAddress], and ReadValid SHALL be 1 for the following cycle only (latency 1).
REQ-023 With simultaneous read and write to the same address, the read SHALL return the pre-write contents (read-before-write).
REQ-024 When no read is accepted, ReadData SHALL hold its last value and ReadValid SHALL be 0; the output is never tristated.
REQ-025 Back-to-back reads SHALL be accepted every cycle, with ReadValid continuously high.

Reset
REQ-026 Reset=1 SHALL immediately, without waiting for Clk, force state=SWEEP, ptr=0, ReadData=0 and ReadValid=0.
REQ-027 Busy SHALL be 1 throughout reset; after deassertion the sweep runs 2**ADDR_W cycles, then Busy falls.
REQ-028 Reset asserted mid-sweep or mid-read SHALL restart the sweep from ptr=0 and discard any pending ReadValid.
REQ-029 Memory contents SHALL NOT be reset asynchronously; they are defined only by the sweep.

Verification
REQ-030 Default params: release Reset -> Busy=1 for exactly 256 cycles, then 0; reads of addresses 0, 128 and 255 -> ReadData=0x00 with ReadValid pulses.
REQ-031 Write addr 0x10 data 0xA5 mask 0xFF; write addr 0x10 data 0x0F mask 0x0F; read 0x10 -> ReadData=0xAF one cycle after the read.
REQ-032 Same cycle: write 0x3C to addr 5 (holding 0x11) and read addr 5 -> ReadData=0x11; next read of addr 5 -> 0x3C.
REQ-033 Pulse Clear, then attempt write 0xFF to addr 7 and a read during Busy -> no ReadValid; after Busy falls, read addr 7 -> 0x00.
REQ-034 Assert Reset during cycle 40 of a sweep -> ReadData=0 and ReadValid=0 immediately; Busy lasts a full 256 cycles after release.
REQ-035 DATA_W=16, ADDR_W=4, CLEAR_VAL=0xBEEF: Busy lasts 16 cycles; read addr 15 -> 0xBEEF; masked write 0x1234 with mask 0xFF00 -> 0x12EF.
